// File: rtl/note_sequencer_pkg.sv
// Shared audio definitions: field widths, note word layout and sequencer state encoding.
// The tone generator uses the same widths and tone range.
package note_sequencer_pkg;

  localparam int TONE_W = 6;
  localparam int VOL_W  = 4;
  localparam int DUR_W  = 10;
  localparam int NOTE_W = TONE_W + VOL_W + DUR_W;

  localparam int TONE_LSB = 0;
  localparam int VOL_LSB  = TONE_LSB + TONE_W;
  localparam int DUR_LSB  = VOL_LSB + VOL_W;

  localparam logic [TONE_W-1:0] TONE_MAX = TONE_W'(48);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} seq_state_t;

  // Codes 0 and above TONE_MAX, or a silent volume, are rests.
  function automatic logic is_playable(input logic [TONE_W-1:0] tone,
                                       input logic [VOL_W-1:0]  vol);
    return (tone != '0) && (tone <= TONE_MAX) && (vol != '0);
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Note stream handshake plus tone generator control outputs.
interface note_sequencer_if;
  import note_sequencer_pkg::*;

  logic [NOTE_W-1:0] note_data;
  logic              note_valid;
  logic              note_ready;
  logic              stop;
  logic [TONE_W-1:0] tone;
  logic              en;
  logic [VOL_W-1:0]  vol;
  logic              busy;
  logic              done;

  modport master (
    output note_data, note_valid, stop,
    input  note_ready, tone, en, vol, busy, done
  );

  modport slave (
    input  note_data, note_valid, stop,
    output note_ready, tone, en, vol, busy, done
  );

endinterface

// File: rtl/note_sequencer_ms_tick.sv
// Duration tick prescaler: one-cycle pulse every TICK_CYCLES clocks, restartable by a
// synchronous clear so the first tick after a clear lands exactly TICK_CYCLES cycles later.
module ms_tick #(
  parameter int TICK_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr || (r_cnt == LAST)) r_cnt <= '0;
    else                          r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: accepts note words, plays each for its duration, inserts a silent gap,
// then signals DONE and accepts the next note in that same cycle.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int TICK_CYCLES = 100000,
  parameter int GAP_TICKS   = 10
) (
  input logic              i_clk,
  input logic              i_rst,
  note_sequencer_if.slave  io_note
);

  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_TICKS);

  seq_state_t        r_state, w_state_nxt;
  logic [DUR_W-1:0]  r_dur,   w_dur_nxt;
  logic [GAP_W-1:0]  r_gap,   w_gap_nxt;
  logic [TONE_W-1:0] r_tone,  w_tone_nxt;
  logic [VOL_W-1:0]  r_vol,   w_vol_nxt;
  logic              r_en,    w_en_nxt;
  logic              r_done,  w_done_nxt;
  logic              r_busy;

  logic              w_ready, w_accept, w_tick;
  logic [TONE_W-1:0] w_in_tone;
  logic [VOL_W-1:0]  w_in_vol;
  logic [DUR_W-1:0]  w_in_dur;

  assign w_in_tone = io_note.note_data[TONE_LSB +: TONE_W];
  assign w_in_vol  = io_note.note_data[VOL_LSB  +: VOL_W];
  assign w_in_dur  = io_note.note_data[DUR_LSB  +: DUR_W];

  assign w_ready  = (r_state == S_IDLE) && !io_note.stop && !i_rst;
  assign w_accept = io_note.note_valid && w_ready;

  // Restarting the prescaler at accept makes every note tick exactly TICK_CYCLES long.
  ms_tick #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .i_clk  (i_clk),
    .i_clr  (i_rst || io_note.stop || w_accept),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_dur_nxt   = r_dur;
    w_gap_nxt   = r_gap;
    w_tone_nxt  = r_tone;
    w_vol_nxt   = r_vol;
    w_en_nxt    = r_en;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_in_dur == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_PLAY;
            w_dur_nxt   = w_in_dur;
            w_vol_nxt   = w_in_vol;
            w_en_nxt    = is_playable(w_in_tone, w_in_vol);
            w_tone_nxt  = is_playable(w_in_tone, w_in_vol) ? w_in_tone : '0;
          end
        end
      end
      S_PLAY: begin
        if (w_tick) begin
          if (r_dur == DUR_W'(1)) begin
            w_dur_nxt  = '0;
            w_en_nxt   = 1'b0;
            w_tone_nxt = '0;
            if (GAP_TICKS > 0) begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = GAP_INIT;
            end else begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_dur_nxt = r_dur - 1'b1;
          end
        end
      end
      S_GAP: begin
        if (w_tick) begin
          if (r_gap == GAP_W'(1)) begin
            w_state_nxt = S_IDLE;
            w_gap_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_gap_nxt = r_gap - 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort silences the generator and drops any pending completion.
    if (io_note.stop) begin
      w_state_nxt = S_IDLE;
      w_dur_nxt   = '0;
      w_gap_nxt   = '0;
      w_tone_nxt  = '0;
      w_vol_nxt   = '0;
      w_en_nxt    = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_dur   <= '0;
      r_gap   <= '0;
      r_tone  <= '0;
      r_vol   <= '0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dur   <= w_dur_nxt;
      r_gap   <= w_gap_nxt;
      r_tone  <= w_tone_nxt;
      r_vol   <= w_vol_nxt;
      r_en    <= w_en_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign io_note.note_ready = w_ready;
  assign io_note.tone       = r_tone;
  assign io_note.vol        = r_vol;
  assign io_note.en         = r_en;
  assign io_note.busy       = r_busy;
  assign io_note.done       = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a gap build and a no-gap build driven by the same stimulus,
// each compared every cycle against a timeline model of note start/end times.
module tb_note_sequencer;

  localparam int T = 10;
  localparam int GAP0 = 2;
  localparam int GAP1 = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  note_sequencer_if if0 ();
  note_sequencer_if if1 ();

  note_sequencer #(.TICK_CYCLES(T), .GAP_TICKS(GAP0)) u_dut0 (.i_clk(clk), .i_rst(rst), .io_note(if0));
  note_sequencer #(.TICK_CYCLES(T), .GAP_TICKS(GAP1)) u_dut1 (.i_clk(clk), .i_rst(rst), .io_note(if1));

  int n_checks = 0;
  int n_errors = 0;

  // Timeline model: cycle index c is the state after the c-th rising edge.
  int cyc = 0;
  bit armed = 1'b0;
  int gap_ticks [2] = '{GAP0, GAP1};
  int m_play_end [2];
  int m_end [2];
  bit m_done_ok [2];
  bit m_en [2];
  int m_tone [2];
  int m_vol [2];
  bit acc [2];

  int cnt_en [2];
  int cnt_busy [2];
  int cnt_done [2];
  int cnt_gaplow [2];
  int acc_cyc [2];
  int first_done [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 30) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [19:0] note(input int t, input int v, input int d);
    return {d[9:0], v[3:0], t[5:0]};
  endfunction

  task automatic clear_cnt();
    for (int k = 0; k < 2; k++) begin
      cnt_en[k] = 0; cnt_busy[k] = 0; cnt_done[k] = 0; cnt_gaplow[k] = 0;
      acc_cyc[k] = -1; first_done[k] = -1;
    end
  endtask

  task automatic chk_dut(input int k, input logic en, input logic [5:0] tone, input logic [3:0] vol,
                         input logic busy, input logic done);
    bit inp;
    inp = (cyc < m_play_end[k]);
    check($sformatf("en%0d", k), 32'(en), 32'(inp && m_en[k]));
    check($sformatf("tone%0d", k), 32'(tone), (inp && m_en[k]) ? m_tone[k] : 0);
    check($sformatf("vol%0d", k), 32'(vol), m_vol[k]);
    check($sformatf("busy%0d", k), 32'(busy), 32'(cyc < m_end[k]));
    check($sformatf("done%0d", k), 32'(done), 32'((cyc == m_end[k]) && m_done_ok[k]));
    if (en === 1'b1) cnt_en[k]++;
    if (busy === 1'b1) cnt_busy[k]++;
    if (busy === 1'b1 && en === 1'b0) cnt_gaplow[k]++;
    if (done === 1'b1) begin
      cnt_done[k]++;
      if (first_done[k] < 0) first_done[k] = cyc;
    end
  endtask

  // One clock: apply inputs, check ready, advance model and DUT, check registered outputs.
  task automatic step(input bit v, input logic [19:0] d, input bit s, input bit r);
    int nc;
    int dur, tn, vl;
    if0.note_valid = v; if0.note_data = d; if0.stop = s;
    if1.note_valid = v; if1.note_data = d; if1.stop = s;
    rst = r;
    #1;
    nc = cyc + 1;
    dur = int'(d[19:10]); vl = int'(d[9:6]); tn = int'(d[5:0]);
    for (int k = 0; k < 2; k++) begin
      acc[k] = armed && v && (cyc >= m_end[k]) && !s && !r;
      if (armed) begin
        if (k == 0) check("ready0", 32'(if0.note_ready), 32'((cyc >= m_end[0]) && !s && !r));
        else        check("ready1", 32'(if1.note_ready), 32'((cyc >= m_end[1]) && !s && !r));
      end
      if (r || s) begin
        m_end[k] = nc; m_play_end[k] = nc; m_done_ok[k] = 1'b0; m_vol[k] = 0; m_en[k] = 1'b0;
      end else if (acc[k]) begin
        acc_cyc[k] = nc;
        m_done_ok[k] = 1'b1;
        if (dur == 0) begin
          m_end[k] = nc;
        end else begin
          m_play_end[k] = nc + dur * T;
          m_end[k] = m_play_end[k] + gap_ticks[k] * T;
          m_vol[k] = vl;
          m_tone[k] = tn;
          m_en[k] = (tn >= 1) && (tn <= 48) && (vl != 0);
        end
      end
    end
    if (r) armed = 1'b1;
    @(posedge clk);
    cyc = nc;
    @(negedge clk);
    if (armed) begin
      chk_dut(0, if0.en, if0.tone, if0.vol, if0.busy, if0.done);
      chk_dut(1, if1.en, if1.tone, if1.vol, if1.busy, if1.done);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 20'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [19:0] q [3];
    int idx;
    if0.note_valid = 1'b0; if0.note_data = '0; if0.stop = 1'b0;
    if1.note_valid = 1'b0; if1.note_data = '0; if1.stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_play_end[k] = 0; m_end[k] = 0; m_done_ok[k] = 0; m_en[k] = 0; m_tone[k] = 0; m_vol[k] = 0;
    end
    clear_cnt();
    @(negedge clk);
    step(1'b0, 20'h0, 1'b0, 1'b1);
    step(1'b0, 20'h0, 1'b0, 1'b1);
    idle(2);

    // Reset in the middle of a note
    step(1'b1, note(12, 8, 3), 1'b0, 1'b0);
    idle(14);
    step(1'b0, 20'h0, 1'b0, 1'b1);
    idle(3);

    // Playable note with gap
    clear_cnt();
    step(1'b1, note(12, 8, 3), 1'b0, 1'b0);
    idle(55);
    check("t2_en_len", 32'(cnt_en[0]), 30);
    check("t2_gap_len", 32'(cnt_gaplow[0]), 20);
    check("t2_done_cnt", 32'(cnt_done[0]), 1);
    check("t2_done_pos", 32'(first_done[0] - acc_cyc[0]), 50);

    // Rests and zero-duration note
    clear_cnt();
    step(1'b1, note(0, 8, 2), 1'b0, 1'b0);
    idle(45);
    step(1'b1, note(49, 8, 2), 1'b0, 1'b0);
    idle(45);
    check("t3_rest_en", 32'(cnt_en[0] + cnt_en[1]), 0);
    check("t3_busy0", 32'(cnt_busy[0]), 80);
    check("t3_busy1", 32'(cnt_busy[1]), 40);
    check("t3_done", 32'(cnt_done[0]), 2);
    clear_cnt();
    step(1'b1, note(5, 3, 0), 1'b0, 1'b0);
    idle(3);
    check("t3_dur0_busy", 32'(cnt_busy[0] + cnt_busy[1]), 0);
    check("t3_dur0_done", 32'(first_done[0] - acc_cyc[0]), 0);

    // Back-to-back with VALID held
    clear_cnt();
    q[0] = note(20, 5, 1); q[1] = note(30, 9, 2); q[2] = note(7, 15, 1);
    idx = 0;
    for (int i = 0; i < 200 && idx < 3; i++) begin
      if (idx > 0 && cyc >= m_end[0]) check("t4_acc_on_done", 32'(if0.done), 1);
      step(1'b1, q[idx], 1'b0, 1'b0);
      if (acc[0]) idx++;
    end
    check("t4_accepts", 32'(idx), 3);
    idle(50);
    check("t4_done_cnt", 32'(cnt_done[0]), 3);

    // STOP mid-note with a note offered during STOP
    clear_cnt();
    step(1'b1, note(12, 8, 3), 1'b0, 1'b0);
    idle(14);
    step(1'b1, note(40, 4, 2), 1'b1, 1'b0);
    step(1'b1, note(40, 4, 2), 1'b1, 1'b0);
    idle(40);
    check("t5_done_cnt", 32'(cnt_done[0]), 0);
    check("t5_en_len", 32'(cnt_en[0]), 15);

    // No-gap build: dur=1
    clear_cnt();
    step(1'b1, note(3, 2, 1), 1'b0, 1'b0);
    idle(15);
    check("t6_en_len", 32'(cnt_en[1]), 10);
    check("t6_done_pos", 32'(first_done[1] - acc_cyc[1]), 10);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int rv;
      logic [19:0] d;
      rv = int'($urandom_range(0, 99));
      d = note(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
      step(rv < 60, d, $urandom_range(0, 59) == 0, $urandom_range(0, 199) == 0);
    end
    idle(80);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
